// File: rtl/module_volume.sv
// module_volume -- output volume stage between the IIR low-pass filter and
// the DAC/serializer.
//
// Each 18-bit signed sample from the filter is scaled by an 8-bit gain
// (128 = unity). The gain target comes from MIDI CC 7 (channel volume).
// The product is built by a serial shift-add over the 8 gain bits, so the
// block needs no hardware multiplier.
//
// Build option:
//   MODULE_VOLUME_RAMP_EN  defined   : once per sample, cur_gain moves toward
//                                       target_gain by at most RAMP_STEP. This
//                                       suppresses zipper noise.
//                          undefined : cur_gain jumps to target_gain on every
//                                       sample. RAMP_STEP is not used.
//   Latency is the same in both builds.
//
// Ports:
//   clk             system clock
//   reset_n         synchronous active-low reset
//   midi_rdy        one-cycle strobe; the MIDI fields below are valid
//   midi_cmd        decoded MIDI command
//   midi_ch_sysn    MIDI channel
//   midi_data0      controller number
//   midi_data1      controller value
//   sample_in_rdy   one-cycle strobe; sample_in is valid
//   sample_in       signed sample from the LPF
//   sample_out_rdy  one-cycle strobe; sample_out is valid
//   sample_out      scaled signed sample; holds its value until the next result
//   busy            high while a sample is in flight
//   overrun         sticky; a sample arrived while the block was busy

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 4
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 4'd3
`endif

module module_volume #(
    parameter logic [3:0] MIDI_CH   = 4'h0,
    parameter logic [6:0] CC_NUM    = 7'd7,
    parameter logic [7:0] INIT_GAIN = 8'd128,
    parameter logic [7:0] RAMP_STEP = 8'd1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      midi_rdy,
    input  logic [`MIDI_CMD_SIZE-1:0] midi_cmd,
    input  logic [3:0]                midi_ch_sysn,
    input  logic [6:0]                midi_data0,
    input  logic [6:0]                midi_data1,
    input  logic                      sample_in_rdy,
    input  logic signed [17:0]        sample_in,
    output logic                      sample_out_rdy,
    output logic signed [17:0]        sample_out,
    output logic                      busy,
    output logic                      overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic signed [17:0]  sample_q;
    logic [7:0]          cur_gain;
    logic [7:0]          target_gain;
    logic [7:0]          cur_gain_nxt;
    logic signed [25:0]  acc;
    logic [2:0]          bit_cnt;

    logic                cc_hit;
    logic [7:0]          cc_gain;
    logic signed [25:0]  sample_ext;
    logic signed [25:0]  partial;

    // Bit 6 of the CC value adds one. This makes 127 map to exact unity
    // (128), while 0..63 pass through unchanged.
    assign cc_hit  = midi_rdy && (midi_cmd == `MIDI_CMD_CC) &&
                     (midi_ch_sysn == MIDI_CH) && (midi_data0 == CC_NUM);
    assign cc_gain = {1'b0, midi_data1} + {7'd0, midi_data1[6]};

    assign sample_ext = 26'(sample_q);
    assign partial    = sample_ext <<< bit_cnt;

    // The final result is acc >>> 7 truncated to 18 bits. With |sample| <= 2^17
    // and gain <= 128, acc[25] is only a copy of the sign. It is never needed.
    logic unused_acc_msb;
    assign unused_acc_msb = acc[25];

    // ------------------------------------------------------------------
    // Gain update that is applied in LOAD
    // ------------------------------------------------------------------
`ifdef MODULE_VOLUME_RAMP_EN
    logic [7:0] gain_up_dist;
    logic [7:0] gain_dn_dist;

    assign gain_up_dist = target_gain - cur_gain;
    assign gain_dn_dist = cur_gain - target_gain;

    // The step is compared against the remaining distance before it is
    // added or subtracted. The gain therefore snaps to target instead of
    // overshooting or wrapping through 0/255.
    always_comb begin
        cur_gain_nxt = target_gain;
        if (cur_gain < target_gain) begin
            if (gain_up_dist > RAMP_STEP)
                cur_gain_nxt = cur_gain + RAMP_STEP;
        end else if (cur_gain > target_gain) begin
            if (gain_dn_dist > RAMP_STEP)
                cur_gain_nxt = cur_gain - RAMP_STEP;
        end
    end
`else
    logic unused_ramp_step;
    assign unused_ramp_step = ^RAMP_STEP;

    always_comb begin
        cur_gain_nxt = target_gain;
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (sample_in_rdy) state_nxt = LOAD;
            LOAD: state_nxt = MULT;
            MULT: if (bit_cnt == 3'd7) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sample_q       <= '0;
            cur_gain       <= INIT_GAIN;
            target_gain    <= INIT_GAIN;
            acc            <= '0;
            bit_cnt        <= '0;
            sample_out     <= '0;
            sample_out_rdy <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            // The CC write can happen in any state. LOAD reads the registered
            // target, so a write in the same cycle as LOAD takes effect on
            // the next sample.
            if (cc_hit)
                target_gain <= cc_gain;

            if (sample_in_rdy && (state != IDLE))
                overrun <= 1'b1;

            busy           <= (state_nxt != IDLE);
            sample_out_rdy <= (state == DONE);

            case (state)
                IDLE: begin
                    if (sample_in_rdy)
                        sample_q <= sample_in;
                end
                LOAD: begin
                    cur_gain <= cur_gain_nxt;
                    acc      <= '0;
                    bit_cnt  <= '0;
                end
                MULT: begin
                    if (cur_gain[bit_cnt])
                        acc <= acc + partial;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                DONE: begin
                    // Take bits [24:7]. This is an arithmetic shift right
                    // by 7, so the result is rounded toward -inf.
                    sample_out <= acc[24:7];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_module_volume.sv
`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 4
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 4'd3
`endif

module tb_module_volume;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      midi_rdy = 1'b0;
    logic [`MIDI_CMD_SIZE-1:0] midi_cmd = '0;
    logic [3:0]                midi_ch_sysn = '0;
    logic [6:0]                midi_data0 = '0;
    logic [6:0]                midi_data1 = '0;
    logic                      sample_in_rdy = 1'b0;
    logic signed [17:0]        sample_in = '0;
    logic                      sample_out_rdy;
    logic signed [17:0]        sample_out;
    logic                      busy;
    logic                      overrun;

    localparam logic [`MIDI_CMD_SIZE-1:0] CMD_CC    = `MIDI_CMD_CC;
    localparam logic [`MIDI_CMD_SIZE-1:0] CMD_OTHER = CMD_CC + 1'b1;

    module_volume dut (
        .clk(clk), .reset_n(reset_n),
        .midi_rdy(midi_rdy), .midi_cmd(midi_cmd), .midi_ch_sysn(midi_ch_sysn),
        .midi_data0(midi_data0), .midi_data1(midi_data1),
        .sample_in_rdy(sample_in_rdy), .sample_in(sample_in),
        .sample_out_rdy(sample_out_rdy), .sample_out(sample_out),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // The reference model holds the gain as plain integers.
    int m_cur = 128;
    int m_tgt = 128;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_cc(input logic [`MIDI_CMD_SIZE-1:0] cmd, input logic [3:0] ch,
                            input logic [6:0] num, input logic [6:0] val);
        if (cmd == CMD_CC && ch == 4'h0 && num == 7'd7)
            m_tgt = (int'(val) >= 64) ? int'(val) + 1 : int'(val);
    endtask

    // This task advances the gain one sample. It returns floor(s * gain / 128).
    task automatic model_sample(input int s, output int res);
        longint p;
        longint q;
`ifdef MODULE_VOLUME_RAMP_EN
        if (m_cur < m_tgt)      m_cur = (m_tgt - m_cur > 1) ? m_cur + 1 : m_tgt;
        else if (m_cur > m_tgt) m_cur = (m_cur - m_tgt > 1) ? m_cur - 1 : m_tgt;
`else
        m_cur = m_tgt;
`endif
        p = longint'(s) * longint'(m_cur);
        q = p / 128;
        if (p < 0 && (p % 128) != 0) q = q - 1;
        res = int'(q);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        midi_rdy = 1'b0;
        sample_in_rdy = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_cur = 128;
        m_tgt = 128;
    endtask

    task automatic send_cc(input logic [`MIDI_CMD_SIZE-1:0] cmd, input logic [3:0] ch,
                           input logic [6:0] num, input logic [6:0] val);
        midi_cmd = cmd; midi_ch_sysn = ch; midi_data0 = num; midi_data1 = val;
        midi_rdy = 1'b1;
        @(negedge clk);
        midi_rdy = 1'b0;
        model_cc(cmd, ch, num, val);
    endtask

    // The task is entered on a negedge, and that cycle is T. It checks that
    // busy is high for T+1..T+10 and that sample_out_rdy is high only at
    // T+11. If drop_at > 0, it injects a second sample in cycle T+drop_at.
    // It returns on the negedge of T+11.
    task automatic run_sample(input logic signed [17:0] s, input int drop_at,
                              input logic signed [17:0] s2,
                              output logic signed [17:0] got, output bit tim_ok);
        sample_in = s;
        sample_in_rdy = 1'b1;
        tim_ok = 1'b1;
        got = '0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            sample_in_rdy = 1'b0;
            if (k == drop_at) begin
                sample_in = s2;
                sample_in_rdy = 1'b1;
            end
            if (busy !== (k <= 10)) tim_ok = 1'b0;
            if (sample_out_rdy !== (k == 11)) tim_ok = 1'b0;
        end
        got = sample_out;
    endtask

    task automatic sample_check(input string name, input logic signed [17:0] s);
        int e;
        logic signed [17:0] got;
        bit ok;
        model_sample(int'(s), e);
        run_sample(s, -1, '0, got, ok);
        check(name, got, e);
        check({name, " timing"}, ok, 1);
    endtask

    typedef struct {
        bit                        do_cc;
        logic [`MIDI_CMD_SIZE-1:0] cmd;
        logic [3:0]                ch;
        logic [6:0]                num;
        logic [6:0]                val;
        logic signed [17:0]        s;
        logic signed [17:0]        exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic signed [17:0] got;
        bit ok;
        int e;
        bit saw;

        tbl[0] = '{1'b1, CMD_CC,    4'h1, 7'd7,  7'd0,   18'sd1000,    18'sd1000};
        tbl[1] = '{1'b1, CMD_CC,    4'h0, 7'd10, 7'd0,  -18'sd1000,   -18'sd1000};
        tbl[2] = '{1'b1, CMD_OTHER, 4'h0, 7'd7,  7'd0,   18'sd500,     18'sd500};
        tbl[3] = '{1'b1, CMD_CC,    4'h0, 7'd7,  7'd127,-18'sd131072, -18'sd131072};
        tbl[4] = '{1'b0, CMD_CC,    4'h0, 7'd7,  7'd0,   18'sd131071,  18'sd131071};
        tbl[5] = '{1'b0, CMD_CC,    4'h0, 7'd7,  7'd0,   18'sd1,       18'sd1};
        tbl[6] = '{1'b0, CMD_CC,    4'h0, 7'd7,  7'd0,  -18'sd1,      -18'sd1};
        tbl[7] = '{1'b0, CMD_CC,    4'h0, 7'd7,  7'd0,   18'sd0,       18'sd0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset sample_out", sample_out, 0);
        check("reset sample_out_rdy", sample_out_rdy, 0);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // First sample at unity. The output pulse is one cycle wide and the
        // value holds after it.
        run_sample(18'sd1000, -1, '0, got, ok);
        check("unity 1000", got, 1000);
        check("unity timing", ok, 1);
        @(negedge clk);
        check("rdy single pulse", sample_out_rdy, 0);
        check("sample_out holds", sample_out, 1000);

        // Table of ignored CCs and boundary samples at unity
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].do_cc) send_cc(tbl[i].cmd, tbl[i].ch, tbl[i].num, tbl[i].val);
            model_sample(int'(tbl[i].s), e);
            run_sample(tbl[i].s, -1, '0, got, ok);
            check($sformatf("vec%0d value", i), got, tbl[i].exp);
            check($sformatf("vec%0d model", i), got, e);
            check($sformatf("vec%0d timing", i), ok, 1);
        end

        // CC 7 value 64 gives a target gain of 65
        send_cc(CMD_CC, 4'h0, 7'd7, 7'd64);
`ifdef MODULE_VOLUME_RAMP_EN
        begin
            int exp5[5];
            exp5 = '{992, 984, 976, 968, 960};
            for (int i = 0; i < 5; i++) begin
                model_sample(1000, e);
                run_sample(18'sd1000, -1, '0, got, ok);
                check($sformatf("ramp step %0d", i), got, exp5[i]);
                check($sformatf("ramp step %0d timing", i), ok, 1);
            end
            for (int i = 0; i < 58; i++)
                sample_check($sformatf("ramp down %0d", i), 18'sd1000);
        end
`else
        model_sample(1000, e);
        run_sample(18'sd1000, -1, '0, got, ok);
        check("gain65 1000", got, 507);
        check("gain65 timing", ok, 1);
`endif
        model_sample(-1000, e);
        run_sample(-18'sd1000, -1, '0, got, ok);
        check("gain65 -1000 floor", got, -508);

`ifndef MODULE_VOLUME_RAMP_EN
        send_cc(CMD_CC, 4'h0, 7'd7, 7'd0);
        model_sample(12345, e);
        run_sample(18'sd12345, -1, '0, got, ok);
        check("gain0", got, 0);
`endif

        // Overrun: the extra sample at T+5 is dropped. The next sample at
        // T+11 is accepted.
        do_reset();
        run_sample(18'sd1000, 5, 18'sd777, got, ok);
        check("overrun first result", got, 1000);
        check("overrun first timing", ok, 1);
        check("overrun set", overrun, 1);
        run_sample(18'sd2000, -1, '0, got, ok);
        check("accept at T+11", got, 2000);
        check("accept at T+11 timing", ok, 1);
        check("overrun sticky", overrun, 1);

        // Reset in mid-flight: no result pulse, and the gain returns to unity
        do_reset();
        send_cc(CMD_CC, 4'h0, 7'd7, 7'd64);
        sample_check("pre-abort", 18'sd1000);
        sample_in = 18'sd1000;
        sample_in_rdy = 1'b1;
        saw = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            sample_in_rdy = 1'b0;
            if (sample_out_rdy) saw = 1'b1;
            if (k == 6) reset_n = 1'b0;
            if (k == 7) reset_n = 1'b1;
        end
        m_cur = 128;
        m_tgt = 128;
        check("abort no rdy", saw, 0);
        check("abort sample_out", sample_out, 0);
        check("abort overrun", overrun, 0);
        run_sample(18'sd1000, -1, '0, got, ok);
        check("after abort unity", got, 1000);
        check("after abort timing", ok, 1);

        // Random CCs and samples checked against the model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(2, 0) == 0) begin
                logic [3:0] ch;
                logic [6:0] num;
                logic [6:0] val;
                logic [`MIDI_CMD_SIZE-1:0] cmd;
                ch  = ($urandom_range(3, 0) == 0) ? 4'h1 : 4'h0;
                num = ($urandom_range(3, 0) == 0) ? 7'($urandom) : 7'd7;
                cmd = ($urandom_range(5, 0) == 0) ? CMD_OTHER : CMD_CC;
                val = 7'($urandom);
                send_cc(cmd, ch, num, val);
            end
            begin
                int rs;
                logic signed [17:0] s;
                rs = int'($urandom_range(262143, 0)) - 131072;
                s = rs[17:0];
                sample_check($sformatf("rand %0d", i), s);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
